// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: writable control registers and read-only status registers.
// Latency: a write responds one cycle after both AW and W are available; a read returns one cycle after the AR handshake.
// Backpressure: AW/W stall while a channel is held or a B response is pending; AR stalls while an R response is pending.
// Ports: s3_axi_* is the AXI4-Lite slave (single clock, async active-low reset);
//        status_in carries per-register status (read-only slices only); reg_out exposes the writable registers.
module axil_regbank #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   RESP_WIDTH = 2,
  parameter int                   NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           s3_axi_aclk,
  input  logic                           s3_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s3_axi_awaddr,
  input  logic                           s3_axi_awvalid,
  output logic                           s3_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s3_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s3_axi_wstrb,
  input  logic                           s3_axi_wvalid,
  output logic                           s3_axi_wready,
  output logic [RESP_WIDTH-1:0]          s3_axi_bresp,
  output logic                           s3_axi_bvalid,
  input  logic                           s3_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s3_axi_araddr,
  input  logic                           s3_axi_arvalid,
  output logic                           s3_axi_arready,
  output logic [DATA_WIDTH-1:0]          s3_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s3_axi_rresp,
  output logic                           s3_axi_rvalid,
  input  logic                           s3_axi_rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  // Low address bits only select a byte inside a word; decode ignores them.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s3_axi_awaddr[ADDR_LSB-1:0], s3_axi_araddr[ADDR_LSB-1:0]};

  // State
  logic                  ready_en_q;
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q,   rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Handshakes. ready_en_q keeps every ready low until the first edge after reset release.
  logic aw_hs, w_hs, ar_hs;
  assign s3_axi_awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign s3_axi_wready  = ready_en_q & ~w_held_q  & ~bvalid_q;
  assign s3_axi_arready = ready_en_q & ~rvalid_q;
  assign aw_hs = s3_axi_awvalid & s3_axi_awready;
  assign w_hs  = s3_axi_wvalid  & s3_axi_wready;
  assign ar_hs = s3_axi_arvalid & s3_axi_arready;

  // Write operands come from the holding registers if already captured, else straight from the bus.
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_commit;
  assign wr_idx    = aw_held_q ? aw_idx_q : s3_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data   = w_held_q  ? w_data_q : s3_axi_wdata;
  assign wr_strb   = w_held_q  ? w_strb_q : s3_axi_wstrb;
  assign wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign rd_idx    = s3_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Address decode by comparison against every register so out-of-range indices never index arrays.
  logic                  wr_hit, wr_ro, rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;
  always_comb begin
    wr_hit = 1'b0;
    wr_ro  = 1'b0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(wr_idx) == i) begin
        wr_hit = 1'b1;
        wr_ro  = RO_MASK[i];
      end
      if (int'(rd_idx) == i) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Write path next state
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    if (bvalid_q && s3_axi_bready) bvalid_d = 1'b0;
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_hit && !wr_ro) begin
        bresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (int'(wr_idx) == i && wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else begin
      // Only one channel has arrived: park it until its partner shows up.
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = s3_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = s3_axi_wdata;
        w_strb_d = s3_axi_wstrb;
      end
    end
  end

  // Read path next state; rd_val samples regs_q, so a same-edge write is not visible to this read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s3_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? rd_val : '0;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      regs_q     <= '{default: '0};
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

  assign s3_axi_bvalid = bvalid_q;
  assign s3_axi_bresp  = bresp_q;
  assign s3_axi_rvalid = rvalid_q;
  assign s3_axi_rdata  = rdata_q;
  assign s3_axi_rresp  = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank (4 registers, register 3 read-only, 32-bit data).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam logic [NR-1:0] RO = 4'b1000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-1:0]  s3_axi_awaddr;
  logic           s3_axi_awvalid, s3_axi_awready;
  logic [DW-1:0]  s3_axi_wdata;
  logic [DW/8-1:0] s3_axi_wstrb;
  logic           s3_axi_wvalid, s3_axi_wready;
  logic [1:0]     s3_axi_bresp;
  logic           s3_axi_bvalid, s3_axi_bready;
  logic [AW-1:0]  s3_axi_araddr;
  logic           s3_axi_arvalid, s3_axi_arready;
  logic [DW-1:0]  s3_axi_rdata;
  logic [1:0]     s3_axi_rresp;
  logic           s3_axi_rvalid, s3_axi_rready;
  logic [NR*DW-1:0] status_in;
  logic [NR*DW-1:0] reg_out;

  always #5 clk = ~clk;

  axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(2), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .s3_axi_aclk(clk), .s3_axi_aresetn(rst_n),
    .s3_axi_awaddr(s3_axi_awaddr), .s3_axi_awvalid(s3_axi_awvalid), .s3_axi_awready(s3_axi_awready),
    .s3_axi_wdata(s3_axi_wdata), .s3_axi_wstrb(s3_axi_wstrb), .s3_axi_wvalid(s3_axi_wvalid),
    .s3_axi_wready(s3_axi_wready),
    .s3_axi_bresp(s3_axi_bresp), .s3_axi_bvalid(s3_axi_bvalid), .s3_axi_bready(s3_axi_bready),
    .s3_axi_araddr(s3_axi_araddr), .s3_axi_arvalid(s3_axi_arvalid), .s3_axi_arready(s3_axi_arready),
    .s3_axi_rdata(s3_axi_rdata), .s3_axi_rresp(s3_axi_rresp), .s3_axi_rvalid(s3_axi_rvalid),
    .s3_axi_rready(s3_axi_rready),
    .status_in(status_in), .reg_out(reg_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents as seen by the bus.
  logic [DW-1:0] model [NR];

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) if (!RO[i]) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  // Applies a write to the model and returns the response it should produce.
  function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                             input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) return 2'd2;
    if (RO[idx]) return 2'd2;
    for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    return 2'd0;
  endfunction

  function automatic logic [DW+1:0] model_read(input logic [AW-1:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) return {32'h0, 2'd2};
    if (RO[idx]) return {status_in[idx*DW +: DW], 2'd0};
    return {model[idx], 2'd0};
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    int cyc = 0;
    resp = 2'bxx;
    s3_axi_bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      s3_axi_awaddr  = addr;
      s3_axi_wdata   = data;
      s3_axi_wstrb   = strb;
      s3_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s3_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = s3_axi_awvalid && s3_axi_awready;
      w_hs  = s3_axi_wvalid && s3_axi_wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      cyc++;
    end
    @(negedge clk);
    s3_axi_awvalid = 1'b0;
    s3_axi_wvalid  = 1'b0;
    cyc = 0;
    while (!s3_axi_bvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (s3_axi_bvalid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", addr, s3_axi_bvalid);
    end else begin
      resp = s3_axi_bresp;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    int cyc = 0;
    data = 'x;
    resp = 'x;
    s3_axi_rready = 1'b1;
    @(negedge clk);
    s3_axi_araddr  = addr;
    s3_axi_arvalid = 1'b1;
    while (!s3_axi_arready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    s3_axi_arvalid = 1'b0;
    if (s3_axi_rvalid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", addr, s3_axi_rvalid);
    end else begin
      data = s3_axi_rdata;
      resp = s3_axi_rresp;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s3_axi_awaddr = '0; s3_axi_awvalid = 1'b0; s3_axi_wdata = '0; s3_axi_wstrb = '0;
    s3_axi_wvalid = 1'b0; s3_axi_bready = 1'b0; s3_axi_araddr = '0; s3_axi_arvalid = 1'b0;
    s3_axi_rready = 1'b0; status_in = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({s3_axi_awready, s3_axi_wready, s3_axi_arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_readies got=%b required 000", {s3_axi_awready, s3_axi_wready, s3_axi_arready});
    end
    n_tests++;
    if ({s3_axi_bvalid, s3_axi_rvalid, s3_axi_bresp, s3_axi_rresp} !== 6'b0 || s3_axi_rdata !== '0) begin
      n_fail++; $display("FAIL reset_resp bv=%b rv=%b rdata=%h required all 0", s3_axi_bvalid, s3_axi_rvalid, s3_axi_rdata);
    end
    n_tests++;
    if (reg_out !== '0) begin n_fail++; $display("FAIL reset_regout got=%h required 0", reg_out); end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({s3_axi_awready, s3_axi_wready, s3_axi_arready} !== 3'b000) begin
      n_fail++; $display("FAIL release_readies_early got=%b required 000", {s3_axi_awready, s3_axi_wready, s3_axi_arready});
    end
    @(negedge clk);
    n_tests++;
    if ({s3_axi_awready, s3_axi_wready, s3_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL release_readies got=%b required 111", {s3_axi_awready, s3_axi_wready, s3_axi_arready});
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    logic [1:0] r;
    s3_axi_awaddr = 8'h00; s3_axi_wdata = 32'h19; s3_axi_wstrb = 4'hF;
    s3_axi_awvalid = 1'b1; s3_axi_wvalid = 1'b1; s3_axi_bready = 1'b1;
    @(negedge clk);
    s3_axi_awvalid = 1'b0; s3_axi_wvalid = 1'b0;
    void'(model_write(8'h00, 32'h19, 4'hF));
    n_tests++;
    if (s3_axi_bvalid !== 1'b1 || s3_axi_bresp !== 2'd0) begin
      n_fail++; $display("FAIL same_cycle_b bvalid=%b bresp=%0d required 1/0", s3_axi_bvalid, s3_axi_bresp);
    end
    n_tests++;
    if (reg_out[31:0] !== 32'h19) begin n_fail++; $display("FAIL same_cycle_reg0 got=%h required 19", reg_out[31:0]); end
    axi_read(8'h00, d, r);
    n_tests++;
    if (d !== 32'h19 || r !== 2'd0) begin n_fail++; $display("FAIL same_cycle_read got=%h/%0d required 19/0", d, r); end
  endtask

  task automatic test_w_before_aw();
    s3_axi_bready = 1'b1;
    @(negedge clk);
    s3_axi_wdata = 32'h22; s3_axi_wstrb = 4'hF; s3_axi_wvalid = 1'b1;
    @(negedge clk);
    s3_axi_wvalid = 1'b0;
    n_tests++;
    if (s3_axi_wready !== 1'b0) begin n_fail++; $display("FAIL w_first_wready got=%b required 0", s3_axi_wready); end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (s3_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL w_first_early_b cycle=%0d bvalid=%b required 0", c, s3_axi_bvalid); end
      if (c == 2) begin s3_axi_awaddr = 8'h04; s3_axi_awvalid = 1'b1; end
      @(negedge clk);
    end
    s3_axi_awvalid = 1'b0;
    void'(model_write(8'h04, 32'h22, 4'hF));
    n_tests++;
    if (s3_axi_bvalid !== 1'b1 || s3_axi_bresp !== 2'd0) begin
      n_fail++; $display("FAIL w_first_b bvalid=%b bresp=%0d required 1/0", s3_axi_bvalid, s3_axi_bresp);
    end
    n_tests++;
    if (reg_out !== model_flat()) begin n_fail++; $display("FAIL w_first_regs got=%h required %h", reg_out, model_flat()); end
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    axi_write(8'h00, 32'hAABBCCDD, 4'b0010, 0, 0, r);
    void'(model_write(8'h00, 32'hAABBCCDD, 4'b0010));
    n_tests++;
    if (r !== 2'd0 || reg_out[31:0] !== 32'h0000CC19) begin
      n_fail++; $display("FAIL strobe got=%h/%0d required 0000cc19/0", reg_out[31:0], r);
    end
  endtask

  task automatic test_oob();
    logic [DW-1:0] d;
    logic [1:0] r;
    axi_write(8'h10, $urandom, 4'hF, 1, 0, r);
    n_tests++;
    if (r !== 2'd2) begin n_fail++; $display("FAIL oob_bresp got=%0d required 2", r); end
    n_tests++;
    if (reg_out !== model_flat()) begin n_fail++; $display("FAIL oob_regs got=%h required %h", reg_out, model_flat()); end
    axi_read(8'h10, d, r);
    n_tests++;
    if (d !== '0 || r !== 2'd2) begin n_fail++; $display("FAIL oob_read got=%h/%0d required 0/2", d, r); end
  endtask

  task automatic test_ro();
    logic [DW-1:0] d;
    logic [1:0] r;
    status_in = {32'hDEADBEEF, $urandom, $urandom, $urandom};
    axi_write(8'h0C, 32'h12345678, 4'hF, 0, 2, r);
    n_tests++;
    if (r !== 2'd2 || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL ro_write bresp=%0d regs=%h required 2 and %h", r, reg_out, model_flat());
    end
    axi_read(8'h0C, d, r);
    n_tests++;
    if (d !== 32'hDEADBEEF || r !== 2'd0) begin n_fail++; $display("FAIL ro_read got=%h/%0d required deadbeef/0", d, r); end
  endtask

  task automatic test_same_edge_rw();
    logic [1:0] r;
    logic [DW-1:0] v1, v2;
    v1 = $urandom; v2 = ~v1;
    axi_write(8'h08, v1, 4'hF, 0, 0, r);
    void'(model_write(8'h08, v1, 4'hF));
    @(negedge clk);
    s3_axi_awaddr = 8'h08; s3_axi_wdata = v2; s3_axi_wstrb = 4'hF; s3_axi_bready = 1'b1;
    s3_axi_araddr = 8'h08; s3_axi_rready = 1'b0;
    s3_axi_awvalid = 1'b1; s3_axi_wvalid = 1'b1; s3_axi_arvalid = 1'b1;
    n_tests++;
    if ({s3_axi_awready, s3_axi_wready, s3_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL rw_readies got=%b required 111", {s3_axi_awready, s3_axi_wready, s3_axi_arready});
    end
    @(negedge clk);
    s3_axi_awvalid = 1'b0; s3_axi_wvalid = 1'b0; s3_axi_arvalid = 1'b0;
    void'(model_write(8'h08, v2, 4'hF));
    n_tests++;
    if (s3_axi_rvalid !== 1'b1 || s3_axi_rdata !== v1 || s3_axi_rresp !== 2'd0) begin
      n_fail++; $display("FAIL rw_read_old rv=%b rdata=%h required 1 and %h", s3_axi_rvalid, s3_axi_rdata, v1);
    end
    n_tests++;
    if (s3_axi_bvalid !== 1'b1 || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL rw_write bv=%b regs=%h required 1 and %h", s3_axi_bvalid, reg_out, model_flat());
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (s3_axi_rvalid !== 1'b1 || s3_axi_rdata !== v1 || s3_axi_arready !== 1'b0) begin
        n_fail++; $display("FAIL rw_r_hold rv=%b rdata=%h arready=%b required 1/%h/0", s3_axi_rvalid, s3_axi_rdata, s3_axi_arready, v1);
      end
    end
    s3_axi_rready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (s3_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_r_release rvalid=%b required 0", s3_axi_rvalid); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    logic [3:0] s;
    logic [1:0] r, er;
    logic [DW+1:0] exp_rd;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
        er = model_write(a, d, s);
        n_tests++;
        if (r !== er || reg_out !== model_flat()) begin
          n_fail++; $display("FAIL rand_write addr=%h bresp=%0d regs=%h required %0d and %h", a, r, reg_out, er, model_flat());
        end
      end else begin
        status_in = {$urandom, $urandom, $urandom, $urandom};
        exp_rd = model_read(a);
        axi_read(a, rd, r);
        n_tests++;
        if ({rd, r} !== exp_rd) begin
          n_fail++; $display("FAIL rand_read addr=%h got=%h/%0d required %h/%0d", a, rd, r, exp_rd[DW+1:2], exp_rd[1:0]);
        end
      end
    end
  endtask

  task automatic test_bready_stall_reset();
    logic [DW-1:0] d;
    d = $urandom;
    @(negedge clk);
    s3_axi_bready = 1'b0;
    s3_axi_awaddr = 8'h04; s3_axi_wdata = d; s3_axi_wstrb = 4'hF;
    s3_axi_awvalid = 1'b1; s3_axi_wvalid = 1'b1;
    @(negedge clk);
    s3_axi_awvalid = 1'b0; s3_axi_wvalid = 1'b0;
    void'(model_write(8'h04, d, 4'hF));
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (s3_axi_bvalid !== 1'b1 || s3_axi_bresp !== 2'd0 || s3_axi_awready !== 1'b0 || s3_axi_wready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold cycle=%0d bv=%b bresp=%0d awr=%b wr=%b required 1/0/0/0",
                           c, s3_axi_bvalid, s3_axi_bresp, s3_axi_awready, s3_axi_wready);
      end
      @(negedge clk);
    end
    n_tests++;
    if (reg_out !== model_flat()) begin n_fail++; $display("FAIL stall_regs got=%h required %h", reg_out, model_flat()); end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    n_tests++;
    if (s3_axi_bvalid !== 1'b0 || reg_out !== '0 || s3_axi_awready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset bv=%b awr=%b regs=%h required 0/0/0", s3_axi_bvalid, s3_axi_awready, reg_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s3_axi_bready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (s3_axi_bvalid !== 1'b0 || s3_axi_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_resp bv=%b rv=%b required 0/0", s3_axi_bvalid, s3_axi_rvalid);
      end
    end
    n_tests++;
    if ({s3_axi_awready, s3_axi_wready, s3_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL post_reset_readies got=%b required 111", {s3_axi_awready, s3_axi_wready, s3_axi_arready});
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_oob();
    test_ro();
    test_same_edge_rw();
    test_random();
    test_bready_stall_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
